hamming_corrector: RTL

- Downstream stage of the Hamming(8,4) SECDED decoder. Captures the received word, the syndrome bits (s1, s2, s3) and the overall parity bit (st) when a transmission is marked valid.
- Corrects single-bit errors, extracts the 4 data bits and classifies the error.
- Keeps saturating error counters and drives a time-multiplexed 2-digit 7-segment display for the board.

---
 rtl/hamming_corrector_if.sv | 37 +++
 rtl/hamming_corrector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_corrector_if.sv
// Decoder-to-corrector bus: the syndrome/flag inputs of one received word plus
// the corrected result and error counters.
// master = decoder side (drives the inputs); slave = hamming_corrector.
interface hamming_corrector_if #(
  parameter int ANCHO_CUENTA = 8
);
  // Decoder side
  logic                    entrada_valida;
  logic [7:0]              recibido;
  logic                    s1;
  logic                    s2;
  logic                    s3;
  logic                    st;
  logic                    error_simple;
  logic                    error_doble;

  // Corrector results
  logic                    salida_valida;
  logic [7:0]              palabra_corregida;
  logic [3:0]              dato_corregido;
  logic [2:0]              posicion_error;
  logic [1:0]              estado;
  logic [ANCHO_CUENTA-1:0] cuenta_simple;
  logic [ANCHO_CUENTA-1:0] cuenta_doble;

  modport master (
    output entrada_valida, recibido, s1, s2, s3, st, error_simple, error_doble,
    input  salida_valida, palabra_corregida, dato_corregido, posicion_error,
           estado, cuenta_simple, cuenta_doble
  );

  modport slave (
    input  entrada_valida, recibido, s1, s2, s3, st, error_simple, error_doble,
    output salida_valida, palabra_corregida, dato_corregido, posicion_error,
           estado, cuenta_simple, cuenta_doble
  );
endinterface

// File: rtl/hamming_corrector.sv
// Hamming(8,4) SECDED correction stage: fixes single-bit errors, classifies, counts, drives 7-seg.
// Latency: entrada_valida -> salida_valida two register stages; full throughput, one word per cycle.
// Backpressure: none; every valid word is accepted and results are never stalled.
// Ports: reloj/reset (sync, active-high); bus (slave modport) carries decoder inputs and results;
// anodos[1:0] active-low digit enables ([0] data, [1] status); segmentos {g..a} active-low.
module hamming_corrector #(
  parameter int DIV_REFRESCO = 50000,
  parameter int ANCHO_CUENTA = 8
) (
  input  logic                reloj,
  input  logic                reset,
  hamming_corrector_if.slave  bus,
  output logic [1:0]          anodos,
  output logic [6:0]          segmentos
);

  localparam int CNT_W = $clog2(DIV_REFRESCO);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_REFRESCO - 1);

  typedef enum logic [1:0] {
    EST_OK      = 2'b00,
    EST_SIMPLE  = 2'b01,
    EST_DOBLE   = 2'b10,
    EST_PARIDAD = 2'b11
  } estado_t;

  // Stage 1: captured decoder inputs
  logic       v1_q;
  logic [7:0] w1_q;
  logic [2:0] p1_q;
  logic       st1_q;
  logic       es1_q;
  logic       ed1_q;

  // Stage 2: results and counters
  logic                    vld_q;
  logic [7:0]              pal_q,  pal_d;
  logic [3:0]              dato_q, dato_d;
  logic [2:0]              pos_q,  pos_d;
  estado_t                 est_q,  est_d;
  logic [ANCHO_CUENTA-1:0] cs_q,   cs_d;
  logic [ANCHO_CUENTA-1:0] cd_q,   cd_d;

  // Display scan
  logic [CNT_W-1:0] refr_q, refr_d;
  logic             sel_q,  sel_d;
  logic [6:0]       digito_on;

  // Correction and classification of the word held in stage 1.
  // A set error_doble always wins, including the illegal both-flags case.
  always_comb begin
    pal_d = w1_q;
    pos_d = 3'd0;
    est_d = EST_OK;
    if (ed1_q) begin
      est_d = EST_DOBLE;
    end else if (es1_q) begin
      pal_d = w1_q ^ (8'd1 << p1_q);
      pos_d = p1_q;
      est_d = EST_SIMPLE;
    end else if ((p1_q == 3'd0) && st1_q) begin
      // Only the overall parity bit is wrong; data bits are untouched.
      pal_d = w1_q ^ 8'h01;
      est_d = EST_PARIDAD;
    end
    dato_d = {pal_d[7], pal_d[6], pal_d[5], pal_d[3]};
  end

  // Saturating counters advance on the edge that publishes the result.
  always_comb begin
    cs_d = cs_q;
    cd_d = cd_q;
    if (v1_q) begin
      if ((est_d == EST_SIMPLE) || (est_d == EST_PARIDAD)) begin
        if (!(&cs_q)) cs_d = cs_q + ANCHO_CUENTA'(1);
      end
      if (est_d == EST_DOBLE) begin
        if (!(&cd_q)) cd_d = cd_q + ANCHO_CUENTA'(1);
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (refr_q == CNT_MAX) begin
      refr_d = '0;
      sel_d  = ~sel_q;
    end else begin
      refr_d = refr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      v1_q   <= 1'b0;
      w1_q   <= 8'd0;
      p1_q   <= 3'd0;
      st1_q  <= 1'b0;
      es1_q  <= 1'b0;
      ed1_q  <= 1'b0;
      vld_q  <= 1'b0;
      pal_q  <= 8'd0;
      dato_q <= 4'd0;
      pos_q  <= 3'd0;
      est_q  <= EST_OK;
      cs_q   <= '0;
      cd_q   <= '0;
      refr_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      v1_q <= bus.entrada_valida;
      if (bus.entrada_valida) begin
        w1_q  <= bus.recibido;
        p1_q  <= {bus.s3, bus.s2, bus.s1};
        st1_q <= bus.st;
        es1_q <= bus.error_simple;
        ed1_q <= bus.error_doble;
      end
      vld_q <= v1_q;
      if (v1_q) begin
        pal_q  <= pal_d;
        dato_q <= dato_d;
        pos_q  <= pos_d;
        est_q  <= est_d;
      end
      cs_q   <= cs_d;
      cd_q   <= cd_d;
      refr_q <= refr_d;
      sel_q  <= sel_d;
    end
  end

  assign bus.salida_valida     = vld_q;
  assign bus.palabra_corregida = pal_q;
  assign bus.dato_corregido    = dato_q;
  assign bus.posicion_error    = pos_q;
  assign bus.estado            = est_q;
  assign bus.cuenta_simple     = cs_q;
  assign bus.cuenta_doble      = cd_q;

  // Active-high {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] glifo(input logic [3:0] v);
    case (v)
      4'h0:    glifo = 7'h3F;
      4'h1:    glifo = 7'h06;
      4'h2:    glifo = 7'h5B;
      4'h3:    glifo = 7'h4F;
      4'h4:    glifo = 7'h66;
      4'h5:    glifo = 7'h6D;
      4'h6:    glifo = 7'h7D;
      4'h7:    glifo = 7'h07;
      4'h8:    glifo = 7'h7F;
      4'h9:    glifo = 7'h6F;
      4'hA:    glifo = 7'h77;
      4'hB:    glifo = 7'h7C;
      4'hC:    glifo = 7'h39;
      4'hD:    glifo = 7'h5E;
      4'hE:    glifo = 7'h79;
      default: glifo = 7'h71;
    endcase
  endfunction

  // Reset blanks the display directly so both anodes are off the whole time
  // reset is held, and exactly one is on whenever it is not.
  always_comb begin
    digito_on = glifo(dato_q);
    if (sel_q) begin
      case (est_q)
        EST_OK:     digito_on = 7'h40;
        EST_SIMPLE: digito_on = glifo({1'b0, pos_q});
        EST_DOBLE:  digito_on = glifo(4'hE);
        default:    digito_on = glifo(4'h0);
      endcase
    end
    if (reset) begin
      anodos    = 2'b11;
      segmentos = 7'h7F;
    end else begin
      anodos    = sel_q ? 2'b01 : 2'b10;
      segmentos = ~digito_on;
    end
  end

endmodule
